gpio_debounce: RTL and testbench

Per-pin debounce and glitch filter between the GPIO pads and the `gpio_in_i` inputs of the APB4 GPIO controller. Each enabled pin's filtered output only follows the pad after the pad has held a new level for a programmable number of prescaled ticks, so bounces and short glitches never reach edge or level interrupt detection. Configuration arrives as static ports driven from a control register bank. The block also emits a one-cycle change pulse per pin.

---
 rtl/gpio_debounce.sv | 91 +++++++++
 tb/tb_gpio_debounce.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// Per-pin debounce/glitch filter in front of the GPIO controller inputs.
// Define GPIO_DEBOUNCE_SYNC_EN to add a 2-flop pad synchronizer.
module gpio_debounce #(
    parameter int unsigned GPIO_NUM    = 32,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [GPIO_NUM-1:0]    gpio_pad_i,
    input  logic [GPIO_NUM-1:0]    en_i,
    input  logic [CNT_WIDTH-1:0]   thresh_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    output logic [GPIO_NUM-1:0]    gpio_filt_o,
    output logic [GPIO_NUM-1:0]    gpio_chg_o
);

    logic [GPIO_NUM-1:0] s;

`ifdef GPIO_DEBOUNCE_SYNC_EN
    logic [GPIO_NUM-1:0] sync1_q, sync2_q;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_pad_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = gpio_pad_i;
`endif

    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   tick;

    // >= rather than == so lowering presc_i below the count never wraps
    assign tick    = (presc_q >= presc_i);
    assign presc_d = tick ? '0 : presc_q + PRESC_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q [GPIO_NUM];
    logic [CNT_WIDTH-1:0] cnt_d [GPIO_NUM];
    logic [GPIO_NUM-1:0]  filt_q, filt_d;
    logic [GPIO_NUM-1:0]  chg_q;

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < int'(GPIO_NUM); i++) begin
            cnt_d[i] = cnt_q[i];
            if (!en_i[i]) begin
                filt_d[i] = s[i];
                cnt_d[i]  = '0;
            end else if (s[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] >= thresh_i) begin
                    filt_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            presc_q <= '0;
            filt_q  <= '0;
            chg_q   <= '0;
            for (int i = 0; i < int'(GPIO_NUM); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            filt_q  <= filt_d;
            chg_q   <= filt_d ^ filt_q;
            for (int i = 0; i < int'(GPIO_NUM); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_filt_o = filt_q;
    assign gpio_chg_o  = chg_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed self-checking bench for gpio_debounce; handles both synchronizer builds.
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] gpio_pad_i;
    logic [31:0] en_i;
    logic [15:0] thresh_i;
    logic [7:0]  presc_i;
    logic [31:0] gpio_filt_o;
    logic [31:0] gpio_chg_o;

    int checks = 0;
    int errors = 0;

    gpio_debounce dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .gpio_pad_i  (gpio_pad_i),
        .en_i        (en_i),
        .thresh_i    (thresh_i),
        .presc_i     (presc_i),
        .gpio_filt_o (gpio_filt_o),
        .gpio_chg_o  (gpio_chg_o)
    );

    always #5 pclk = ~pclk;

    // Outputs are sampled and inputs driven 1 time unit after the edge
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] bseq;
        bseq = 7'b1111011;

        // Reset with pads high, bypass mode
        presetn    = 1'b0;
        gpio_pad_i = 32'hFFFF_FFFF;
        en_i       = '0;
        thresh_i   = 16'd4;
        presc_i    = 8'd0;
        step();
        check("reset_filt", gpio_filt_o, 32'h0);
        check("reset_chg", gpio_chg_o, 32'h0);
        step();
        step();
        presetn = 1'b1;
        for (int i = 0; i < SYNC; i++) begin
            step();
            check("bypass_wait", gpio_filt_o, 32'h0);
        end
        step();
        check("bypass_filt", gpio_filt_o, 32'hFFFF_FFFF);
        check("bypass_chg", gpio_chg_o, 32'hFFFF_FFFF);
        step();
        check("bypass_chg_once", gpio_chg_o, 32'h0);
        check("bypass_hold", gpio_filt_o, 32'hFFFF_FFFF);

        // Bring everything back to 0 through bypass
        gpio_pad_i = '0;
        for (int i = 0; i < SYNC + 2; i++) step();
        check("bypass_low", gpio_filt_o, 32'h0);

        // Debounce pin 0, T=4
        en_i          = 32'hFFFF_FFFF;
        gpio_pad_i[0] = 1'b1;
        for (int i = 0; i < 4 + SYNC; i++) begin
            step();
            check("deb_wait", {31'b0, gpio_filt_o[0]}, 32'h0);
        end
        step();
        check("deb_rise", {31'b0, gpio_filt_o[0]}, 32'h1);
        check("deb_chg", gpio_chg_o, 32'h1);
        step();
        check("deb_chg_once", gpio_chg_o, 32'h0);

        // Glitch of 4 cycles on pin 1, T=4
        gpio_pad_i[1] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        gpio_pad_i[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("glitch_filt", {31'b0, gpio_filt_o[1]}, 32'h0);
            check("glitch_chg", {31'b0, gpio_chg_o[1]}, 32'h0);
            step();
        end

        // Prescale 3, T=2 on pin 2: third tick lands on the 12th edge
        presc_i       = 8'd3;
        thresh_i      = 16'd2;
        gpio_pad_i[2] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            check("presc_wait", {31'b0, gpio_filt_o[2]}, 32'h0);
        end
        step();
        check("presc_accept", {31'b0, gpio_filt_o[2]}, 32'h1);
        check("presc_chg", gpio_chg_o, 32'h4);

        // Prescaler restarted at 0; let it reach 100 under presc 200, then drop to 0
        presc_i       = 8'd200;
        thresh_i      = 16'd0;
        gpio_pad_i[3] = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check("presc_drop_wait", {31'b0, gpio_filt_o[3]}, 32'h0);
        presc_i = 8'd0;
        step();
        check("presc_drop_tick", {31'b0, gpio_filt_o[3]}, 32'h1);

        // Bounce on pin 4, T=3: sequence 1,1,0,1,1,1,1
        thresh_i = 16'd3;
        for (int i = 0; i < 7 + SYNC; i++) begin
            if (i < 7) gpio_pad_i[4] = bseq[i];
            step();
            if (i < 6 + SYNC)
                check("bounce_wait", {31'b0, gpio_filt_o[4]}, 32'h0);
            else
                check("bounce_accept", {31'b0, gpio_filt_o[4]}, 32'h1);
        end

        // Lower threshold 10 -> 2 with count at 5 on pin 5
        thresh_i      = 16'd10;
        gpio_pad_i[5] = 1'b1;
        for (int i = 0; i < 5 + SYNC; i++) step();
        check("thr_wait", {31'b0, gpio_filt_o[5]}, 32'h0);
        thresh_i = 16'd2;
        step();
        check("thr_accept", {31'b0, gpio_filt_o[5]}, 32'h1);

        // Disable pin 6 mid-count
        thresh_i      = 16'd10;
        gpio_pad_i[6] = 1'b1;
        for (int i = 0; i < 3 + SYNC; i++) step();
        check("en_wait", {31'b0, gpio_filt_o[6]}, 32'h0);
        en_i[6] = 1'b0;
        step();
        check("en_bypass", {31'b0, gpio_filt_o[6]}, 32'h1);
        check("en_chg", gpio_chg_o, 32'h40);

        // Reset mid-count on pin 7, then requalify from scratch with T=2
        gpio_pad_i[7] = 1'b1;
        for (int i = 0; i < 2 + SYNC; i++) step();
        presetn = 1'b0;
        step();
        check("mid_reset_filt", gpio_filt_o, 32'h0);
        check("mid_reset_chg", gpio_chg_o, 32'h0);
        presetn  = 1'b1;
        en_i     = 32'hFFFF_FFFF;
        thresh_i = 16'd2;
        for (int i = 0; i < 2 + SYNC; i++) begin
            step();
            check("requal_wait", gpio_filt_o, 32'h0);
        end
        step();
        check("requal_filt", gpio_filt_o, 32'hFD);
        check("requal_chg", gpio_chg_o, 32'hFD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
